serial_frame_rx: RTL and testbench
==================================

// Module: serial_frame_rx
// PURPOSE
//   Serial frame receiver. Recovers DATA_W-bit words from one asynchronous
//   line using the frame format start(0), data LSB-first, even parity, stop(1).
//   It is the receiving end of the team's serial frame link. Its inputs come
//   from the link pin, and its outputs feed the datapath as a one-cycle valid
//   pulse.
// PARAMETERS
//   DATA_W        8   data bits per frame (>=1)
//   CLKS_PER_BIT  4   clk cycles per bit time (>=2); H = CLKS_PER_BIT/2 (int div)
// PORTS
//   clk         in   1       single clock, all state updates on posedge
//   reset       in   1       asynchronous, active-high; clears all state
//   rx_in       in   1       serial line, idle high, asynchronous to clk
//   data_out    out  DATA_W  last good word; updates only with data_valid
//   data_valid  out  1       one-cycle pulse, frame completed with stop=1
//   parity_err  out  1       parity result of last completed frame, held
//   frame_err   out  1       1 = last frame had stop=0, held
//   busy        out  1       1 whenever state != IDLE
// BEHAVIOUR
//   - Reset values: data_out=0, data_valid=0, parity_err=0, frame_err=0, busy=0.
//     The FSM goes to IDLE, the counters clear, and both synchronizer flops go to 1.
//   - rx_in passes through a 2-flop synchronizer; rxs is its output. The FSM
//     sees only rxs.
//   - FSM states are IDLE, START, DATA, PARITY, STOP and WAIT_HIGH. One cycle
//     counter cnt and one bit index idx.
//   - IDLE: rxs==0 at edge t0 -> START, cnt=0. Any low level counts, including
//     a line held low on reset release.
//   - START: sample rxs at t0+H. If 0 -> DATA. If 1 -> IDLE (glitch, no flags).
//   - DATA: bit i (0..DATA_W-1) is sampled at t0+H+(i+1)*CLKS_PER_BIT and
//     shifted in LSB-first. After the last bit -> PARITY.
//   - PARITY: sampled at t0+H+(DATA_W+1)*CLKS_PER_BIT. Error if the XOR of the
//     data bits and the parity bit is 1.
//   - STOP: sampled at ts = t0+H+(DATA_W+2)*CLKS_PER_BIT.
//     * stop=1: on the edge after ts, data_valid=1 for exactly one cycle,
//       data_out=shifted word, parity_err=parity result, frame_err=0.
//       Then -> IDLE.
//     * stop=0: on the edge after ts, frame_err=1, parity_err=0, data_valid
//       stays 0 and data_out is held. Then -> WAIT_HIGH.
//   - WAIT_HIGH: stay until rxs==1, then -> IDLE. A low line is never taken
//     as a new start bit in this state.
//   - The error flags change only at frame completion, as above. A glitch
//     abort leaves them unchanged.
//   - Back-to-back frames: a start bit immediately after a good stop bit is
//     accepted. IDLE is entered in time to see rxs==0 one bit later.
//   - Reset mid-frame: the frame is dropped immediately. No pulse, outputs
//     return to reset values, and the next full frame is received normally.
//   - Input-to-output latency is fixed: 2 sync cycles + H + (DATA_W+2)*CLKS_PER_BIT
//     + 1 cycles, measured from the start-bit falling edge on rx_in to data_valid.
//   - Only rxs feeds the FSM; there are no combinational paths from rx_in to
//     any output.
// TESTING (DATA_W=8, CLKS_PER_BIT=4)
//   1. Assert reset with rx_in=1 -> all outputs 0, busy=0. Release, idle for 20
//      cycles -> no change.
//   2. Frame 0xA5, parity bit 0, stop 1 -> one data_valid pulse with
//      data_out=0xA5, parity_err=0, frame_err=0. The pulse occurs exactly at
//      the latency above, 2+2+40+1 = 45 cycles after the start-bit falling edge.
//   3. Frame 0x07 with parity bit 0 (wrong) -> data_valid pulse,
//      data_out=0x07, parity_err=1.
//   4. Frame 0x3C with stop 0, line held low 10 cycles, then high ->
//      frame_err=1, no data_valid, data_out keeps 0x07, busy stays 1 until
//      rxs high. Then frame 0x5A -> data_out=0x5A, frame_err=0.
//   5. rx_in low for 1 cycle only -> START aborts to IDLE, no data_valid, flags
//      unchanged. Then two back-to-back frames 0x01, 0x80 -> two pulses with
//      the correct data.
//   6. Assert reset during data bit 3 of 0xFF -> outputs 0 immediately. Release,
//      then full frame 0xFF with parity 0 -> data_out=0xFF, no errors.

Source files
------------

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start(0), DATA_W data bits LSB-first, even parity, stop(1).
// A 2-flop synchronizer feeds a counter-timed FSM that samples each bit at mid-bit.
module serial_frame_rx #(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rx_in,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   output logic              parity_err,
   output logic              frame_err,
   output logic              busy
);

   localparam int H  = CLKS_PER_BIT / 2;
   localparam int CW = $clog2(CLKS_PER_BIT + 1);
   localparam int IW = $clog2(DATA_W + 1);

   localparam logic [CW-1:0] HALF_LAST = CW'(H - 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] STOP_DONE = CW'(CLKS_PER_BIT);
   localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_W - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      WAIT_HIGH
   } state_t;

   state_t            state;
   logic              sync1;
   logic              rxs;
   logic [CW-1:0]     cnt;
   logic [IW-1:0]     idx;
   logic [DATA_W-1:0] shreg;
   logic              par;
   logic              stop_bit;

   assign busy = (state != IDLE);

   // STOP captures the stop bit at its mid-point and reports one cycle later,
   // which still leaves IDLE in place before a back-to-back start bit arrives.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1      <= 1'b1;
         rxs        <= 1'b1;
         state      <= IDLE;
         cnt        <= '0;
         idx        <= '0;
         shreg      <= '0;
         par        <= 1'b0;
         stop_bit   <= 1'b0;
         data_out   <= '0;
         data_valid <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         sync1      <= rx_in;
         rxs        <= sync1;
         data_valid <= 1'b0;
         case (state)
            IDLE: begin
               cnt <= '0;
               if (!rxs) begin
                  state <= START;
               end
            end
            START: begin
               if (cnt == HALF_LAST) begin
                  cnt <= '0;
                  idx <= '0;
                  par <= 1'b0;
                  state <= rxs ? IDLE : DATA;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DATA: begin
               if (cnt == BIT_LAST) begin
                  cnt <= '0;
                  shreg <= shreg >> 1;
                  shreg[DATA_W-1] <= rxs;
                  par <= par ^ rxs;
                  if (idx == IDX_LAST) begin
                     state <= PARITY;
                  end else begin
                     idx <= idx + IW'(1);
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            PARITY: begin
               if (cnt == BIT_LAST) begin
                  cnt   <= '0;
                  par   <= par ^ rxs;
                  state <= STOP;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            STOP: begin
               if (cnt == STOP_DONE) begin
                  cnt <= '0;
                  if (stop_bit) begin
                     data_valid <= 1'b1;
                     data_out   <= shreg;
                     parity_err <= par;
                     frame_err  <= 1'b0;
                     state      <= IDLE;
                  end else begin
                     parity_err <= 1'b0;
                     frame_err  <= 1'b1;
                     state      <= WAIT_HIGH;
                  end
               end else begin
                  if (cnt == BIT_LAST) begin
                     stop_bit <= rxs;
                  end
                  cnt <= cnt + CW'(1);
               end
            end
            WAIT_HIGH: begin
               if (rxs) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Self-checking bench for serial_frame_rx: table-driven frames, hand-written
// corner sequences and randomized frames checked against a frame-level model.
module tb_serial_frame_rx;

   localparam int DATA_W = 8;
   localparam int CPB    = 4;
   localparam int H      = CPB / 2;
   localparam int LAT    = 2 + H + (DATA_W + 2) * CPB + 1;

   logic              clk;
   logic              reset;
   logic              rx_in;
   logic [DATA_W-1:0] data_out;
   logic              data_valid;
   logic              parity_err;
   logic              frame_err;
   logic              busy;

   int checks   = 0;
   int failures = 0;
   int cycle    = 0;

   typedef struct {
      int              cyc;
      logic [7:0]      data;
      logic            perr;
      logic            ferr;
   } pulse_t;

   typedef struct {
      logic [7:0] data;
      logic       pbit;
      logic       sbit;
      logic       exp_valid;
      logic [7:0] exp_data;
      logic       exp_perr;
      logic       exp_ferr;
   } vec_t;

   pulse_t pulses[$];
   vec_t   vecs[6];

   serial_frame_rx #(.DATA_W(DATA_W), .CLKS_PER_BIT(CPB)) dut (
      .clk        (clk),
      .reset      (reset),
      .rx_in      (rx_in),
      .data_out   (data_out),
      .data_valid (data_valid),
      .parity_err (parity_err),
      .frame_err  (frame_err),
      .busy       (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cycle <= cycle + 1;

   // Record every cycle data_valid is seen high, with the edge number it followed.
   always @(posedge clk) begin
      #1;
      if (data_valid) begin
         pulses.push_back('{cyc: cycle, data: data_out, perr: parity_err, ferr: frame_err});
      end
   end

   task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive_bit(input logic b, input int n);
      rx_in = b;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic pbit, input logic sbit,
                             output int start);
      start = cycle;
      drive_bit(1'b0, CPB);
      for (int i = 0; i < DATA_W; i++) drive_bit(d[i], CPB);
      drive_bit(pbit, CPB);
      drive_bit(sbit, CPB);
   endtask

   // Sends one frame; a bad stop bit is followed by the line held low for 'hold' cycles.
   task automatic apply_stimulus(input logic [7:0] d, input logic pbit, input logic sbit,
                                 input int hold, output int start);
      send_frame(d, pbit, sbit, start);
      if (!sbit) begin
         drive_bit(1'b0, hold);
         check_val("busy_wait_low", busy, 1);
         check_val("ferr_wait_low", frame_err, 1);
      end
      drive_bit(1'b1, 8);
   endtask

   task automatic check_output(input logic exp_valid, input int start, input logic [7:0] exp_data,
                               input logic exp_perr, input logic exp_ferr);
      check_val("pulse_count", pulses.size(), exp_valid ? 1 : 0);
      if (exp_valid && pulses.size() >= 1) begin
         check_val("pulse_cycle", pulses[0].cyc, start + 1 + LAT);
         check_val("pulse_data", pulses[0].data, exp_data);
         check_val("pulse_perr", pulses[0].perr, exp_perr);
         check_val("pulse_ferr", pulses[0].ferr, exp_ferr);
      end
      check_val("data_out", data_out, exp_data);
      check_val("parity_err", parity_err, exp_perr);
      check_val("frame_err", frame_err, exp_ferr);
      check_val("busy_idle", busy, 0);
      pulses.delete();
   endtask

   task automatic check_reset_outputs(input string tag);
      check_val({tag, "_data_out"}, data_out, 0);
      check_val({tag, "_valid"}, data_valid, 0);
      check_val({tag, "_perr"}, parity_err, 0);
      check_val({tag, "_ferr"}, frame_err, 0);
      check_val({tag, "_busy"}, busy, 0);
   endtask

   initial begin
      int         start;
      int         start2;
      logic [7:0] last_good;
      logic [7:0] d;
      logic       p;
      logic       s;
      logic       e_perr;

      vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
      vecs[1] = '{8'h07, 1'b0, 1'b1, 1'b1, 8'h07, 1'b1, 1'b0};
      vecs[2] = '{8'h3C, 1'b0, 1'b0, 1'b0, 8'h07, 1'b0, 1'b1};
      vecs[3] = '{8'h5A, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0};
      vecs[4] = '{8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
      vecs[5] = '{8'hC3, 1'b1, 1'b1, 1'b1, 8'hC3, 1'b1, 1'b0};

      reset = 1'b1;
      rx_in = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_outputs("rst");
      reset = 1'b0;
      repeat (20) @(negedge clk);
      check_reset_outputs("idle");
      check_val("idle_pulses", pulses.size(), 0);

      for (int i = 0; i < 6; i++) begin
         apply_stimulus(vecs[i].data, vecs[i].pbit, vecs[i].sbit, 10, start);
         check_output(vecs[i].exp_valid, start, vecs[i].exp_data, vecs[i].exp_perr, vecs[i].exp_ferr);
      end

      // One-cycle glitch: aborts in START and leaves the held flags alone.
      rx_in = 1'b0;
      @(negedge clk);
      rx_in = 1'b1;
      repeat (12) @(negedge clk);
      check_output(1'b0, 0, 8'hC3, 1'b1, 1'b0);

      send_frame(8'h01, 1'b1, 1'b1, start);
      send_frame(8'h80, 1'b1, 1'b1, start2);
      drive_bit(1'b1, 8);
      check_val("b2b_count", pulses.size(), 2);
      if (pulses.size() == 2) begin
         check_val("b2b_cycle0", pulses[0].cyc, start + 1 + LAT);
         check_val("b2b_data0", pulses[0].data, 8'h01);
         check_val("b2b_cycle1", pulses[1].cyc, start2 + 1 + LAT);
         check_val("b2b_data1", pulses[1].data, 8'h80);
         check_val("b2b_perr1", pulses[1].perr, 0);
      end
      pulses.delete();

      // Reset in the middle of data bit 3 of 0xFF.
      drive_bit(1'b0, CPB);
      for (int i = 0; i < 3; i++) drive_bit(1'b1, CPB);
      drive_bit(1'b1, 2);
      reset = 1'b1;
      rx_in = 1'b1;
      #1;
      check_reset_outputs("midrst");
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (10) @(negedge clk);
      check_val("midrst_pulses", pulses.size(), 0);
      apply_stimulus(8'hFF, 1'b0, 1'b1, 0, start);
      check_output(1'b1, start, 8'hFF, 1'b0, 1'b0);

      last_good = 8'hFF;
      for (int n = 0; n < 25; n++) begin
         d = 8'($urandom);
         p = 1'($urandom);
         s = ($urandom_range(0, 4) != 0);
         e_perr = s ? ((^d) ^ p) : 1'b0;
         apply_stimulus(d, p, s, int'($urandom_range(3, 8)), start);
         if (s) last_good = d;
         check_output(s, start, last_good, e_perr, !s);
         repeat ($urandom_range(0, 5)) @(negedge clk);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
